// File: rtl/in_channel.sv
// in_channel: host-to-machine input FIFO feeding the "in" instruction.
//   A first-word-fall-through buffer of NIn words with valid/ready on both
//   sides. An in_last marker on an accepted push closes the stream, and eof
//   rises once the closed stream has fully drained.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready   host push side
//   rd_ready/rd_valid/rd_data           machine pop side (rd_data = oldest word)
//   count               buffered words, 0..NIn
//   eof                 stream closed and empty
//   underrun            sticky: pop requested while empty
module in_channel #(
  parameter int unsigned MemoryElementWidth = 12,
  parameter int unsigned NIn                = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [MemoryElementWidth-1:0] in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [MemoryElementWidth-1:0] rd_data,
  output logic [31:0]                   count,
  output logic                          eof,
  output logic                          underrun
);

  localparam int unsigned AW = (NIn > 1) ? $clog2(NIn) : 1;
  localparam int unsigned CW = 32;

  typedef enum logic [1:0] {
    S_OPEN    = 2'd0,
    S_CLOSED  = 2'd1,
    S_DRAINED = 2'd2
  } state_t;

  state_t                          state, state_nx;
  logic [AW-1:0]                   wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [CW-1:0]                   count_nx;
  logic                            push, pop, underrun_nx;
  logic [MemoryElementWidth-1:0]   mem [NIn];

  // State register plus registered status outputs derived from next values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_OPEN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      underrun <= 1'b0;
      rd_valid <= 1'b0;
      eof      <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      wr_ptr   <= wr_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      count    <= count_nx;
      underrun <= underrun_nx;
      rd_valid <= (count_nx != '0);
      eof      <= (state_nx == S_DRAINED);
      in_ready <= (state_nx == S_OPEN) && (count_nx < CW'(NIn));
    end
  end

  // Storage is not cleared by reset; a push during reset is discarded.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  assign rd_data = mem[rd_ptr];

  // Next-state, pointer and count logic.
  always_comb begin
    state_nx    = state;
    wr_ptr_nx   = wr_ptr;
    rd_ptr_nx   = rd_ptr;
    count_nx    = count;
    underrun_nx = underrun;
    push        = in_valid && in_ready;
    pop         = rd_ready && rd_valid;

    if (rd_ready && !rd_valid) begin
      underrun_nx = 1'b1;
    end

    if (push) begin
      wr_ptr_nx = (wr_ptr == AW'(NIn - 1)) ? '0 : wr_ptr + AW'(1);
    end
    if (pop) begin
      rd_ptr_nx = (rd_ptr == AW'(NIn - 1)) ? '0 : rd_ptr + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase

    case (state)
      S_OPEN: begin
        if (push && in_last) begin
          state_nx = S_CLOSED;
        end
      end
      S_CLOSED: begin
        if (count_nx == '0) begin
          state_nx = S_DRAINED;
        end
      end
      S_DRAINED: state_nx = S_DRAINED;
      default:   state_nx = S_OPEN;
    endcase
  end

endmodule
